// File: rtl/usb2_ep_pkg.sv
// Shared types and constants for the usb2 endpoint buffer clients.
package usb2_ep_pkg;

   localparam int unsigned EP_ADDR_W  = 11;
   localparam int unsigned EP_BUF_MAX = 1024;

   typedef enum logic [1:0] {
      S_WAIT_RDY = 2'd0,
      S_FILL     = 2'd1,
      S_COMMIT   = 2'd2,
      S_ACK_WAIT = 2'd3
   } ep_wr_state_e;

endpackage

// File: rtl/usb2_sync2.sv
// Two-flop single-bit synchronizer with synchronous active-high reset.
module usb2_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb2_ep_in_writer.sv
// Stream-to-endpoint writer: fills one buffer half with sequential bytes and
// commits on full packet, s_last, flush or idle timeout, with optional ZLP.
module usb2_ep_in_writer
   import usb2_ep_pkg::*;
#(
   parameter int unsigned MAX_PKT = 512,
   parameter int unsigned TIMEOUT = 1024,
   parameter bit          ZLP_EN  = 1'b1
) (
   input  logic                 wr_clk,
   input  logic                 reset,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_last,
   input  logic                 flush,
   output logic [EP_ADDR_W-1:0] buf_in_addr,
   output logic [7:0]           buf_in_data,
   output logic                 buf_in_wren,
   input  logic                 buf_in_ready,
   output logic                 buf_in_commit,
   output logic [EP_ADDR_W-1:0] buf_in_commit_len,
   input  logic                 buf_in_commit_ack,
   output logic [15:0]          pkt_count,
   output logic                 busy
);

   localparam int unsigned MAX_LEN = (MAX_PKT > EP_BUF_MAX) ? EP_BUF_MAX : MAX_PKT;
   localparam int unsigned TO_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   ep_wr_state_e         state, state_nxt;
   logic [EP_ADDR_W-1:0] count, count_nxt, count_post, len_nxt;
   logic [TO_W-1:0]      to_cnt, to_nxt;
   logic [15:0]          pkt_nxt;
   logic                 zlp_pend, zlp_nxt;
   logic                 rdy_s, ack_s;
   logic                 accept, trig;

   usb2_sync2 u_sync_rdy (.clk(wr_clk), .reset(reset), .d(buf_in_ready),      .q(rdy_s));
   usb2_sync2 u_sync_ack (.clk(wr_clk), .reset(reset), .d(buf_in_commit_ack), .q(ack_s));

   always_ff @(posedge wr_clk) begin
      if (reset) state <= S_WAIT_RDY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = s_valid & s_ready;
      count_post = count + EP_ADDR_W'(accept);
      count_nxt  = count;
      to_nxt     = to_cnt;
      len_nxt    = buf_in_commit_len;
      pkt_nxt    = pkt_count;
      zlp_nxt    = zlp_pend;
      trig       = 1'b0;
      case (state)
         S_WAIT_RDY: begin
            if (rdy_s && zlp_pend) begin
               state_nxt = S_COMMIT;
               len_nxt   = '0;
            end else if (rdy_s) begin
               state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            count_nxt = count_post;
            if (accept || count == '0)            to_nxt = '0;
            else if (to_cnt != TO_W'(TIMEOUT))    to_nxt = to_cnt + TO_W'(1);
            // all triggers look at the count including this cycle's byte
            trig = (count_post == EP_ADDR_W'(MAX_LEN)) ||
                   (accept && s_last) ||
                   (flush && count_post != '0) ||
                   ((TIMEOUT != 0) && to_nxt == TO_W'(TIMEOUT) && count_post != '0);
            if (ZLP_EN && accept && s_last && count_post == EP_ADDR_W'(MAX_LEN))
               zlp_nxt = 1'b1;
            if (trig) begin
               state_nxt = S_COMMIT;
               len_nxt   = count_post;
            end
         end
         S_COMMIT: begin
            if (ack_s) begin
               state_nxt = S_ACK_WAIT;
               pkt_nxt   = pkt_count + 16'd1;
               if (buf_in_commit_len == '0) zlp_nxt = 1'b0;
            end
         end
         S_ACK_WAIT: begin
            if (!ack_s) begin
               state_nxt = S_WAIT_RDY;
               count_nxt = '0;
               to_nxt    = '0;
            end
         end
         default: state_nxt = S_WAIT_RDY;
      endcase
   end

   // commit rises one cycle after entering S_COMMIT so the last write lands first
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         count             <= '0;
         to_cnt            <= '0;
         zlp_pend          <= 1'b0;
         s_ready           <= 1'b0;
         buf_in_wren       <= 1'b0;
         buf_in_addr       <= '0;
         buf_in_data       <= '0;
         buf_in_commit     <= 1'b0;
         buf_in_commit_len <= '0;
         pkt_count         <= '0;
         busy              <= 1'b0;
      end else begin
         count             <= count_nxt;
         to_cnt            <= to_nxt;
         zlp_pend          <= zlp_nxt;
         s_ready           <= (state_nxt == S_FILL);
         buf_in_wren       <= accept;
         if (accept) begin
            buf_in_addr <= count;
            buf_in_data <= s_data;
         end
         buf_in_commit     <= (state == S_COMMIT) && (state_nxt == S_COMMIT);
         buf_in_commit_len <= len_nxt;
         pkt_count         <= pkt_nxt;
         busy              <= (state_nxt != S_WAIT_RDY) || (count_nxt != '0);
      end
   end

endmodule

// File: tb/tb_usb2_ep_in_writer.sv
// Scoreboard bench for usb2_ep_in_writer with a simple endpoint model on phy_clk.
module tb_usb2_ep_in_writer;

   localparam int MAX = 512;

   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic wr_clk = 1'b0;
   logic phy_clk = 1'b0;
   always #5 wr_clk  = ~wr_clk;
   always #6 phy_clk = ~phy_clk;

   logic        reset = 1'b1;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0, s_last = 1'b0, flush = 1'b0;
   logic        s_ready, buf_in_wren, buf_in_commit, busy;
   logic [10:0] buf_in_addr, buf_in_commit_len;
   logic [7:0]  buf_in_data;
   logic [15:0] pkt_count;
   logic        ep_ready = 1'b1, ack_block = 1'b0;
   logic        buf_in_commit_ack = 1'b0;

   logic [7:0]  s_data_z = '0;
   logic        s_valid_z = 1'b0, flush_z = 1'b0;
   logic        s_ready_z, wren_z, commit_z, busy_z;
   logic [10:0] addr_z, len_z;
   logic [7:0]  data_z;
   logic [15:0] pkt_z;
   logic        ack_z = 1'b0;

   usb2_ep_in_writer #(.MAX_PKT(MAX), .TIMEOUT(64), .ZLP_EN(1'b1)) u_dut (
      .wr_clk(wr_clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_last(s_last), .flush(flush), .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
      .buf_in_wren(buf_in_wren), .buf_in_ready(ep_ready), .buf_in_commit(buf_in_commit),
      .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
      .pkt_count(pkt_count), .busy(busy)
   );

   usb2_ep_in_writer #(.MAX_PKT(16), .TIMEOUT(0), .ZLP_EN(1'b1)) u_dut_nto (
      .wr_clk(wr_clk), .reset(reset), .s_data(s_data_z), .s_valid(s_valid_z), .s_ready(s_ready_z),
      .s_last(1'b0), .flush(flush_z), .buf_in_addr(addr_z), .buf_in_data(data_z),
      .buf_in_wren(wren_z), .buf_in_ready(1'b1), .buf_in_commit(commit_z),
      .buf_in_commit_len(len_z), .buf_in_commit_ack(ack_z), .pkt_count(pkt_z), .busy(busy_z)
   );

   // endpoint model: ack follows commit in the phy_clk domain (4-phase)
   always @(posedge phy_clk) begin
      buf_in_commit_ack <= buf_in_commit & ~ack_block;
      ack_z             <= commit_z;
   end

   int  n_tests = 0, n_fail = 0;
   int  cyc = 0;
   wr_t exp_wr[$];
   int  exp_len[$];
   int  exp_addr = 0;
   int  last_acc_cyc = 0, rise_cyc = 0;
   logic        commit_prev = 1'b0;
   logic [10:0] len_prev = '0;
   logic        seen_commit_z = 1'b0;
   wr_t w;
   int  e;

   always @(posedge wr_clk) cyc <= cyc + 1;

   // monitor: pops expected writes and commit lengths as the DUT presents them
   always @(negedge wr_clk) begin
      if (buf_in_wren) begin
         n_tests++;
         if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected: addr=%0d data=%02h, none expected", buf_in_addr, buf_in_data);
         end else begin
            w = exp_wr.pop_front();
            if (w.addr !== buf_in_addr || w.data !== buf_in_data) begin
               n_fail++;
               $display("FAIL wr_data: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                        buf_in_addr, buf_in_data, w.addr, w.data);
            end
         end
      end
      if (buf_in_commit && !commit_prev) begin
         rise_cyc = cyc;
         n_tests++;
         if (exp_len.size() == 0) begin
            n_fail++;
            $display("FAIL commit_unexpected: len=%0d, none expected", buf_in_commit_len);
         end else begin
            e = exp_len.pop_front();
            if (buf_in_commit_len !== 11'(e)) begin
               n_fail++;
               $display("FAIL commit_len: got %0d, expected %0d", buf_in_commit_len, e);
            end
         end
         n_tests++;
         if (buf_in_wren) begin
            n_fail++;
            $display("FAIL wren_before_commit: got wren=1 at commit rise, expected 0");
         end
      end else if (buf_in_commit && commit_prev) begin
         n_tests++;
         if (buf_in_commit_len !== len_prev) begin
            n_fail++;
            $display("FAIL len_hold: got %0d, expected %0d", buf_in_commit_len, len_prev);
         end
      end
      if (commit_z) seen_commit_z = 1'b1;
      commit_prev = buf_in_commit;
      len_prev    = buf_in_commit_len;
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the byte is accepted
   task automatic send(input logic [7:0] d, input logic last);
      int n = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      while (!s_ready && n < 1000) begin @(negedge wr_clk); n++; end
      if (!s_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: s_ready=0 after %0d cycles, expected 1", n);
         s_valid = 1'b0; s_last = 1'b0;
         return;
      end
      exp_wr.push_back({11'(exp_addr), d});
      exp_addr++;
      if (exp_addr == MAX || last || flush) begin
         exp_len.push_back(exp_addr);
         if (last && exp_addr == MAX) exp_len.push_back(0);
         exp_addr = 0;
      end
      @(negedge wr_clk);
      last_acc_cyc = cyc;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic expect_pkt(input int exp);
      int n = 0;
      while (pkt_count !== 16'(exp) && n < 2000) begin @(negedge wr_clk); n++; end
      check("pkt_count", 32'(pkt_count), 32'(exp));
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge wr_clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc;
      repeat (3) @(negedge wr_clk);
      check("rst_flags", 32'({s_ready, buf_in_wren, buf_in_commit, busy}), 32'd0);
      check("rst_addr", 32'(buf_in_addr), 32'd0);
      check("rst_data", 32'(buf_in_data), 32'd0);
      check("rst_len", 32'(buf_in_commit_len), 32'd0);
      check("rst_pkt", 32'(pkt_count), 32'd0);
      reset = 1'b0;
      @(negedge wr_clk);

      // full packet, back-to-back
      for (int i = 0; i < MAX; i++) send(8'(i), 1'b0);
      check("full_sready_low", 32'(s_ready), 32'd0);
      expect_pkt(1);

      // s_last on byte 99
      for (int i = 0; i < 100; i++) send(8'(i + 7), i == 99);
      expect_pkt(2);

      // flush together with the 4th byte
      for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 1'b0);
      flush = 1'b1;
      send(8'hC3, 1'b0);
      flush = 1'b0;
      expect_pkt(3);

      // idle timeout after 5 bytes
      for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b0);
      exp_len.push_back(5);
      exp_addr = 0;
      expect_pkt(4);
      n_tests++;
      if (rise_cyc - last_acc_cyc < 63 || rise_cyc - last_acc_cyc > 66) begin
         n_fail++;
         $display("FAIL timeout_delay: got %0d cycles, expected 63..66", rise_cyc - last_acc_cyc);
      end

      // endpoint backpressure
      for (int i = 0; i < 8; i++) send(8'(8'h80 + i), i == 7);
      ep_ready = 1'b0;
      expect_pkt(5);
      s_valid = 1'b1; s_data = 8'hA5;
      repeat (200) begin
         @(negedge wr_clk);
         check("bp_stall", 32'({s_ready, buf_in_wren}), 32'd0);
      end
      ep_ready = 1'b1;
      n = 0;
      while (!s_ready && n < 10) begin @(negedge wr_clk); n++; end
      n_tests++;
      if (n > 3) begin
         n_fail++;
         $display("FAIL bp_resume: got %0d cycles, expected <=3", n);
      end
      send(8'hA5, 1'b1);
      expect_pkt(6);

      // s_last on exactly a full packet -> ZLP follows
      for (int i = 0; i < MAX; i++) send(8'(i ^ 5), i == MAX - 1);
      expect_pkt(8);
      repeat (20) @(negedge wr_clk);
      check("zlp_once", 32'(pkt_count), 32'd8);

      // reset after 30 accepted bytes
      for (int i = 0; i < 30; i++) send(8'(8'h30 + i), 1'b0);
      pulse_reset();
      exp_addr = 0;
      check("rst30_commit", 32'(buf_in_commit), 32'd0);
      check("rst30_pkt", 32'(pkt_count), 32'd0);
      for (int i = 0; i < 20; i++) send(8'(8'hE0 + i), i == 19);
      expect_pkt(1);

      // reset while commit is held
      ack_block = 1'b1;
      for (int i = 0; i < 10; i++) send(8'(8'h10 + i), i == 9);
      n = 0;
      while (!buf_in_commit && n < 50) begin @(negedge wr_clk); n++; end
      check("commit_seen", 32'(buf_in_commit), 32'd1);
      pulse_reset();
      check("rstc_commit", 32'(buf_in_commit), 32'd0);
      check("rstc_pkt", 32'(pkt_count), 32'd0);
      ack_block = 1'b0;
      for (int i = 0; i < 7; i++) send(8'(8'h70 + i), i == 6);
      expect_pkt(1);

      // TIMEOUT=0 instance: idle never commits, flush does
      acc = 0; n = 0;
      s_valid_z = 1'b1;
      while (acc < 5 && n < 100) begin
         s_data_z = 8'(acc);
         if (s_ready_z) acc++;
         @(negedge wr_clk);
         n++;
      end
      s_valid_z = 1'b0;
      check("nto_accepted", 32'(acc), 32'd5);
      repeat (300) @(negedge wr_clk);
      check("nto_no_commit", 32'(seen_commit_z), 32'd0);
      flush_z = 1'b1;
      n = 0;
      while (!commit_z && n < 50) begin @(negedge wr_clk); n++; end
      flush_z = 1'b0;
      check("nto_flush_len", 32'(len_z), 32'd5);

      repeat (10) @(negedge wr_clk);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      check("len_queue_empty", 32'(exp_len.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/usb2_ep_in_writer.md
Name: usb2_ep_in_writer

Overview:
- Client-side writer that fills the usb2 endpoint double buffer through its buf_in write/commit interface.
- Accepts a byte stream (valid/ready), writes bytes at sequential addresses and commits a packet on any of these triggers:
  - max packet size reached
  - end-of-stream
  - explicit flush
  - idle timeout
- Sits in the wr_clk domain and synchronises the endpoint's phy_clk-side ready/ack status internally.
- The endpoint instance it drives must have fast_commit=0; the 1-cycle ack pulse is not guaranteed visible across domains.

Parameters:
MAX_PKT, 512, bytes per full packet; legal range 1..1024, one endpoint buffer half.
TIMEOUT, 1024, idle wr_clk cycles after the last accepted byte before a partial packet is committed; 0 disables the timeout.
ZLP_EN, 1, send a zero-length packet when s_last lands exactly on a full packet.

Ports:
wr_clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
s_data  in  8  stream byte.
s_valid  in  1  s_data valid.
s_ready  out  1  writer accepts byte this cycle; transfer = s_valid & s_ready.
s_last  in  1  with an accepted byte: last byte of a transfer, commit after it.
flush  in  1  level; commit the pending partial packet if it holds >0 bytes.
buf_in_addr  out  11  endpoint write address, 0-based within the current buffer.
buf_in_data  out  8  endpoint write data.
buf_in_wren  out  1  endpoint write strobe.
buf_in_ready  in  1  endpoint current buffer free (phy_clk domain).
buf_in_commit  out  1  commit request; level held until ack.
buf_in_commit_len  out  11  byte count of the committed packet.
buf_in_commit_ack  in  1  endpoint commit acknowledge (phy_clk domain).
pkt_count  out  16  committed packets, wraps at 65535->0.
busy  out  1  high when state is not S_WAIT_RDY or byte count is non-zero.

Behaviour:
- Reset values: s_ready=0, buf_in_wren=0, buf_in_commit=0, buf_in_addr=0, buf_in_data=0, buf_in_commit_len=0, pkt_count=0, busy=0, byte count=0, state=S_WAIT_RDY.
- Reset synchronizer flops clear to 0.
- Synchronisation:
  - buf_in_ready and buf_in_commit_ack each pass a 2-flop synchronizer, giving rdy_s and ack_s.
  - FSM decisions use only rdy_s and ack_s.
- S_WAIT_RDY: s_ready=0. Go to S_FILL when rdy_s=1 and a pending-ZLP flag is clear. If rdy_s=1 and pending-ZLP is set, go to S_COMMIT with len 0.
- S_FILL: s_ready=1.
  - Each accepted byte: next cycle wren=1, addr=count, data=byte (1-cycle write latency); count increments.
  - Commit triggers, evaluated on the post-accept count:
    - count reaches MAX_PKT
    - accepted byte has s_last=1
    - flush=1 with count>0
    - timeout counter reaches TIMEOUT with count>0
  - On any trigger: latch commit_len=count and go to S_COMMIT. s_ready drops the same cycle the trigger is registered.
  - No further byte is accepted until the next S_FILL.
  - Same-cycle byte and flush: the byte is included, then the packet is committed.
  - Timeout counter: clears on every accepted byte and whenever count=0; otherwise increments in S_FILL; saturates.
  - flush with count=0: ignored, no empty commit.
- S_COMMIT:
  - buf_in_commit=1 and commit_len stable. The final wren always precedes the commit rising edge by at least 1 cycle.
  - Wait for ack_s=1, then go to S_ACK_WAIT and increment pkt_count.
- S_ACK_WAIT: commit=0. Wait for ack_s=0; the endpoint has swapped buffers by then. Clear count, go to S_WAIT_RDY.
- ZLP:
  - With ZLP_EN=1, s_last on the byte that makes count=MAX_PKT sets pending-ZLP.
  - After that packet completes, one commit with len 0 follows; pending-ZLP clears on its ack.
- Backpressure: if rdy_s=0, stay in S_WAIT_RDY indefinitely with s_ready=0 and no writes.
- Reset mid-operation:
  - Partial data is discarded and the count is cleared.
  - Any asserted commit drops in the same cycle.
  - An ack already in flight is ignored: the FSM restarts in S_WAIT_RDY.

Decomposition:
- Package usb2_ep_pkg holds:
  - FSM state encoding (S_WAIT_RDY, S_FILL, S_COMMIT, S_ACK_WAIT)
  - EP_ADDR_W=11
  - EP_BUF_MAX=1024
- One sub-module, usb2_sync2: 2-flop bit synchronizer with synchronous active-high reset, instantiated twice (ready, ack).

Test Plan:
- MAX_PKT=512, 512 back-to-back bytes -> wren at addr 0..511 with matching data, commit=1 with len=512 held until ack, pkt_count=1, s_ready=0 until the endpoint model re-asserts ready.
- 100 bytes with s_last on byte 99 -> commit len=100; next packet starts at addr 0.
- TIMEOUT=64, 5 bytes then s_valid=0 -> commit len=5 asserted 64 cycles (±1 sync) after the last accept; with TIMEOUT=0 no commit ever occurs.
- Endpoint model holds ready=0 for 200 cycles (both halves full) -> s_ready=0, no wren; ready=1 -> filling resumes within 3 cycles.
- ZLP_EN=1, s_last on the 512th byte -> commit len=512, ack, then commit len=0, pkt_count=2.
- Reset after 30 accepted bytes (and separately while commit=1) -> commit low next cycle, no pkt_count change; next packet writes from addr 0 with a correct length.
